// File: rtl/lcd_rx_model_pkg.sv
// Shared definitions for the character-LCD receiver: FSM states, opcode masks, address helpers.
// Latency: n/a (package).
// Backpressure: n/a (package).
package lcd_pkg;

    typedef enum logic [1:0] {
        ST_8BIT = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2,
        ST_CLR  = 2'd3
    } lcd_state_e;

    // Command class, chosen by the highest set bit of the command byte
    typedef enum logic [3:0] {
        K_NOP   = 4'd0,
        K_CLEAR = 4'd1,
        K_HOME  = 4'd2,
        K_ENTRY = 4'd3,
        K_DISP  = 4'd4,
        K_SHIFT = 4'd5,
        K_FUNC  = 4'd6,
        K_CGRAM = 4'd7,
        K_DDRAM = 4'd8
    } cmd_kind_e;

    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] CMD_SET_CGRAM = 8'h40;
    localparam logic [7:0] CMD_FUNC_SET  = 8'h20;
    localparam logic [7:0] CMD_SHIFT     = 8'h10;
    localparam logic [7:0] CMD_DISP_CTRL = 8'h08;
    localparam logic [7:0] CMD_ENTRY     = 8'h04;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam int         LINE_LEN   = 16;
    localparam int         NUM_CELLS  = 2 * LINE_LEN;

    // Last DDRAM address of each 40-character line bank
    localparam logic [6:0] LINE1_END = 7'h27;
    localparam logic [6:0] LINE2_END = 7'h67;

    function automatic cmd_kind_e decode_cmd(input logic [7:0] b);
        cmd_kind_e k;
        if      ((b & CMD_SET_DDRAM) != 8'h00) k = K_DDRAM;
        else if ((b & CMD_SET_CGRAM) != 8'h00) k = K_CGRAM;
        else if ((b & CMD_FUNC_SET)  != 8'h00) k = K_FUNC;
        else if ((b & CMD_SHIFT)     != 8'h00) k = K_SHIFT;
        else if ((b & CMD_DISP_CTRL) != 8'h00) k = K_DISP;
        else if ((b & CMD_ENTRY)     != 8'h00) k = K_ENTRY;
        else if ((b & CMD_HOME)      != 8'h00) k = K_HOME;
        else if ((b & CMD_CLEAR)     != 8'h00) k = K_CLEAR;
        else                                   k = K_NOP;
        return k;
    endfunction

    // Two-line address map: each line is a 40-entry bank, the banks chain into a ring
    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
        logic [6:0] n;
        if (inc) begin
            if      (a == LINE1_END) n = LINE2_BASE;
            else if (a == LINE2_END) n = 7'h00;
            else                     n = a + 7'd1;
        end else begin
            if      (a == LINE2_BASE) n = LINE1_END;
            else if (a == 7'h00)      n = LINE2_END;
            else                      n = a - 7'd1;
        end
        return n;
    endfunction

    // {visible, cell index}: only the first 16 columns of each line are displayed
    function automatic logic [5:0] cell_of(input logic [6:0] a);
        logic [5:0] c;
        if      (a[6:4] == 3'b000) c = {1'b1, 1'b0, a[3:0]};
        else if (a[6:4] == 3'b100) c = {1'b1, 1'b1, a[3:0]};
        else                       c = 6'd0;
        return c;
    endfunction

endpackage

// File: rtl/lcd_rx_model_if.sv
// Character-LCD write bus (E strobe, RS, RW, upper data nibble).
// Latency: none, wires only.
// Backpressure: none; the bus has no read path, the driver paces itself.
interface lcd_rx_model_if;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [3:0] lcd_dat;

    modport master (output lcd_e, lcd_rs, lcd_rw, lcd_dat);
    modport slave  (input  lcd_e, lcd_rs, lcd_rw, lcd_dat);
endinterface

// File: rtl/lcd_bus_sync.sv
// Synchronises the LCD bus into clk and flags the falling edge of E.
// Latency: SYNC_STAGES cycles to the strobe; strobe is combinational off the last stage.
// Backpressure: none; one strobe per E falling edge.
module lcd_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_e,
    input  logic       i_rs,
    input  logic       i_rw,
    input  logic [3:0] i_dat,
    output logic       o_strobe,
    output logic       o_rs,
    output logic       o_rw,
    output logic [3:0] o_dat
);

    logic [6:0] r_sync [SYNC_STAGES];
    logic       r_e_last;
    logic [6:0] w_out;

    assign w_out = r_sync[SYNC_STAGES-1];

    // Shift all bus lines together through the synchroniser chain and remember E
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 7'd0;
            r_e_last <= 1'b0;
        end else begin
            r_sync[0] <= {i_e, i_rs, i_rw, i_dat};
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_e_last <= w_out[6];
        end
    end

    // Strobe on synchronised E going 1->0; RS/RW/DAT sampled in that same cycle
    always_comb begin
        o_strobe = r_e_last & ~w_out[6];
        o_rs     = w_out[5];
        o_rw     = w_out[4];
        o_dat    = w_out[3:0];
    end

endmodule

// File: rtl/lcd_rx_model.sv
// HD44780-subset receiver: nibble reassembly, command execution, 2x16 character image.
// Latency: 1 cycle from synchronised E fall to byte_vld / screen update.
// Backpressure: none; strobes during clear or with RW=1 are dropped with a proto_err pulse.
module lcd_rx_model
    import lcd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CLR_CYCLES  = 32
) (
    input  logic           clk,
    input  logic           rst,
    lcd_rx_model_if.slave  bus,
    output logic [255:0]   screen,
    output logic           byte_vld,
    output logic           byte_rs,
    output logic [7:0]     byte_dat,
    output logic           busy,
    output logic           disp_on,
    output logic           four_bit,
    output logic           proto_err
);

    localparam int             CW       = $clog2(CLR_CYCLES);
    localparam logic [CW-1:0]  CLR_LAST = CW'(CLR_CYCLES - 1);

    logic          w_strobe, w_rs, w_rw;
    logic [3:0]    w_dat;

    lcd_state_e    r_state, w_state_nx;
    logic [3:0]    r_hi;
    logic [6:0]    r_addr;
    logic          r_inc;
    logic          r_disp_on, r_four_bit;
    logic          r_byte_vld, r_byte_rs, r_proto_err;
    logic [7:0]    r_byte_dat;
    logic [CW-1:0] r_clr_cnt;
    logic [7:0]    r_ddram [NUM_CELLS];

    logic          w_take, w_drop, w_exec, w_hi_ld, w_four_nx;
    logic          w_clr_last, w_clr_cell_ok;
    logic [7:0]    w_byte;
    cmd_kind_e     w_kind;
    logic [5:0]    w_cell;

    lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .i_e      (bus.lcd_e),
        .i_rs     (bus.lcd_rs),
        .i_rw     (bus.lcd_rw),
        .i_dat    (bus.lcd_dat),
        .o_strobe (w_strobe),
        .o_rs     (w_rs),
        .o_rw     (w_rw),
        .o_dat    (w_dat)
    );

    assign w_clr_last    = (r_state == ST_CLR) && (r_clr_cnt == CLR_LAST);
    assign w_clr_cell_ok = (r_clr_cnt >> 5) == '0;
    assign w_kind        = decode_cmd(w_byte);
    assign w_cell        = cell_of(r_addr);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_8BIT;
        else      r_state <= w_state_nx;
    end

    // Next state plus per-strobe decode: accept/drop, nibble latch, byte completion
    always_comb begin
        w_state_nx = r_state;
        w_take     = 1'b0;
        w_drop     = 1'b0;
        w_exec     = 1'b0;
        w_hi_ld    = 1'b0;
        w_byte     = 8'h00;
        w_four_nx  = r_four_bit;

        if (w_strobe) begin
            if (w_rw || (r_state == ST_CLR)) w_drop = 1'b1;
            else                             w_take = 1'b1;
        end

        case (r_state)
            ST_8BIT: if (w_take) begin
                w_exec = 1'b1;
                w_byte = {w_dat, 4'h0};
            end
            ST_HI: if (w_take) begin
                w_hi_ld    = 1'b1;
                w_state_nx = ST_LO;
            end
            ST_LO: if (w_take) begin
                w_exec = 1'b1;
                w_byte = {r_hi, w_dat};
            end
            ST_CLR: if (w_clr_last) begin
                w_state_nx = r_four_bit ? ST_HI : ST_8BIT;
            end
            default: w_state_nx = ST_8BIT;
        endcase

        // A completed byte decides the next nibble phase from the (possibly new) bus width
        if (w_exec) begin
            if (!w_rs && (w_kind == K_FUNC)) w_four_nx = ~w_byte[4];
            if (!w_rs && (w_kind == K_CLEAR)) w_state_nx = ST_CLR;
            else                              w_state_nx = w_four_nx ? ST_HI : ST_8BIT;
        end
    end

    // Control registers: byte report, error pulse, address/entry mode, display flags, clear counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi        <= 4'h0;
            r_addr      <= 7'h00;
            r_inc       <= 1'b1;
            r_disp_on   <= 1'b0;
            r_four_bit  <= 1'b0;
            r_byte_vld  <= 1'b0;
            r_byte_rs   <= 1'b0;
            r_byte_dat  <= 8'h00;
            r_proto_err <= 1'b0;
            r_clr_cnt   <= '0;
        end else begin
            r_byte_vld  <= w_exec;
            r_proto_err <= w_drop;
            r_four_bit  <= w_four_nx;
            if (w_hi_ld) r_hi <= w_dat;
            if (w_exec) begin
                r_byte_rs  <= w_rs;
                r_byte_dat <= w_byte;
                if (w_rs) begin
                    r_addr <= addr_step(r_addr, r_inc);
                end else begin
                    case (w_kind)
                        K_DDRAM: r_addr    <= w_byte[6:0];
                        K_DISP:  r_disp_on <= w_byte[2];
                        K_ENTRY: r_inc     <= w_byte[1];
                        K_HOME:  r_addr    <= 7'h00;
                        default: ;
                    endcase
                end
            end
            if (r_state == ST_CLR) begin
                r_clr_cnt <= w_clr_last ? '0 : r_clr_cnt + 1'b1;
                if (w_clr_last) begin
                    r_addr <= 7'h00;
                    r_inc  <= 1'b1;
                end
            end
        end
    end

    // Character cells: clear sweeps one cell per cycle, data writes hit visible addresses only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_CELLS; k++) r_ddram[k] <= CHAR_SPACE;
        end else if ((r_state == ST_CLR) && w_clr_cell_ok) begin
            r_ddram[r_clr_cnt[4:0]] <= CHAR_SPACE;
        end else if (w_exec && w_rs && w_cell[5]) begin
            r_ddram[w_cell[4:0]] <= w_byte;
        end
    end

    // Pack cells into the screen word, cell 0 (line 1 col 0) in the top byte
    always_comb begin
        screen = '0;
        for (int k = 0; k < NUM_CELLS; k++) screen[255-8*k -: 8] = r_ddram[k];
    end

    assign byte_vld  = r_byte_vld;
    assign byte_rs   = r_byte_rs;
    assign byte_dat  = r_byte_dat;
    assign busy      = (r_state == ST_CLR);
    assign disp_on   = r_disp_on;
    assign four_bit  = r_four_bit;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_lcd_rx_model.sv
// Directed + randomised bench for lcd_rx_model against a character-level display model.
// Latency: checks taken several cycles after each strobe settles.
// Backpressure: strobes are paced by the bench; busy periods are awaited with bounds.
module tb_lcd_rx_model;

    localparam int CLR = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lcd_rx_model_if bus ();

    logic [255:0] screen;
    logic         byte_vld, byte_rs, busy, disp_on, four_bit, proto_err;
    logic [7:0]   byte_dat;

    lcd_rx_model #(.SYNC_STAGES(2), .CLR_CYCLES(CLR)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .screen    (screen),
        .byte_vld  (byte_vld),
        .byte_rs   (byte_rs),
        .byte_dat  (byte_dat),
        .busy      (busy),
        .disp_on   (disp_on),
        .four_bit  (four_bit),
        .proto_err (proto_err)
    );

    int checks = 0;
    int errors = 0;

    // Observed pulse activity
    int         vld_cyc = 0, perr_cyc = 0, busy_cyc = 0;
    logic [7:0] last_byte = 8'h00;
    logic       last_rs = 1'b0;
    always @(negedge clk) begin
        if (byte_vld) begin vld_cyc++; last_byte = byte_dat; last_rs = byte_rs; end
        if (proto_err) perr_cyc++;
        if (busy) busy_cyc++;
    end

    // Reference model: character grid, cursor in the 80-position DDRAM ring
    logic [7:0] m_cell [32];
    int         m_addr;
    bit         m_inc, m_disp, m_four, m_lo;
    logic [3:0] m_hi;
    int         exp_vld = 0, exp_perr = 0;
    logic [7:0] exp_byte = 8'h00;

    task automatic model_reset();
        for (int k = 0; k < 32; k++) m_cell[k] = 8'h20;
        m_addr = 0; m_inc = 1; m_disp = 0; m_four = 0; m_lo = 0; m_hi = 4'h0;
    endtask

    function automatic int step(int a, bit inc);
        int lin;
        lin = (a >= 64) ? a - 64 + 40 : a;
        lin = inc ? (lin + 1) % 80 : (lin + 79) % 80;
        return (lin >= 40) ? lin - 40 + 64 : lin;
    endfunction

    task automatic model_exec(bit rs, logic [7:0] b);
        exp_vld++;
        exp_byte = b;
        if (rs) begin
            if (m_addr < 16) m_cell[m_addr] = b;
            else if (m_addr >= 64 && m_addr < 80) m_cell[m_addr - 64 + 16] = b;
            m_addr = step(m_addr, m_inc);
        end else if (b >= 8'h80) m_addr = int'(b) - 128;
        else if (b >= 8'h40) ;
        else if (b >= 8'h20) m_four = !b[4];
        else if (b >= 8'h10) ;
        else if (b >= 8'h08) m_disp = b[2];
        else if (b >= 8'h04) m_inc = b[1];
        else if (b >= 8'h02) m_addr = 0;
        else if (b == 8'h01) begin
            for (int k = 0; k < 32; k++) m_cell[k] = 8'h20;
            m_addr = 0; m_inc = 1;
        end
    endtask

    task automatic model_nib(bit rs, bit rw, logic [3:0] d);
        if (rw) exp_perr++;
        else if (!m_four) model_exec(rs, {d, 4'h0});
        else if (!m_lo) begin m_hi = d; m_lo = 1; end
        else begin m_lo = 0; model_exec(rs, {m_hi, d}); end
    endtask

    function automatic logic [255:0] model_screen();
        logic [255:0] v;
        for (int k = 0; k < 32; k++) v[255-8*k -: 8] = m_cell[k];
        return v;
    endfunction

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".screen"}, screen, model_screen());
        chk({tag, ".four_bit"}, 256'(four_bit), 256'(m_four));
        chk({tag, ".disp_on"}, 256'(disp_on), 256'(m_disp));
        chk({tag, ".vld_cycles"}, 256'(vld_cyc), 256'(exp_vld));
        chk({tag, ".perr_cycles"}, 256'(perr_cyc), 256'(exp_perr));
        if (exp_vld > 0) chk({tag, ".last_byte"}, 256'(last_byte), 256'(exp_byte));
    endtask

    task automatic strobe(bit rs, bit rw, logic [3:0] d);
        bus.lcd_rs = rs; bus.lcd_rw = rw; bus.lcd_dat = d;
        @(posedge clk); #1 bus.lcd_e = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.lcd_e = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic send_nib(bit rs, bit rw, logic [3:0] d);
        strobe(rs, rw, d);
        model_nib(rs, rw, d);
    endtask

    task automatic send_byte(bit rs, logic [7:0] b, bit rw_between);
        send_nib(rs, 1'b0, b[7:4]);
        if (rw_between) send_nib(rs, 1'b1, 4'($urandom_range(0, 15)));
        send_nib(rs, 1'b0, b[3:0]);
    endtask

    function automatic logic [7:0] rand_char();
        return 8'($urandom_range(8'h21, 8'h7E));
    endfunction

    function automatic logic [7:0] rand_cmd();
        logic [7:0] c;
        case ($urandom_range(0, 6))
            0: c = 8'h20 | 8'($urandom_range(0, 15));
            1: c = 8'h08 | 8'($urandom_range(0, 7));
            2: c = 8'h04 | 8'($urandom_range(0, 3));
            3: c = 8'h02 | 8'($urandom_range(0, 1));
            4: c = 8'h10 | 8'($urandom_range(0, 15));
            5: c = 8'h40 | 8'($urandom_range(0, 63));
            default: c = 8'h80 | 8'($urandom_range(0, 1) * 64 + $urandom_range(0, 39));
        endcase
        return c;
    endfunction

    initial begin
        logic [7:0] c;
        int         b0, n;

        bus.lcd_e = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_dat = 4'h0;
        rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst.screen", screen, {32{8'h20}});
        chk("rst.byte_vld", 256'(byte_vld), 256'(0));
        chk("rst.byte_rs", 256'(byte_rs), 256'(0));
        chk("rst.byte_dat", 256'(byte_dat), 256'(0));
        chk("rst.busy", 256'(busy), 256'(0));
        chk("rst.disp_on", 256'(disp_on), 256'(0));
        chk("rst.four_bit", 256'(four_bit), 256'(0));
        chk("rst.proto_err", 256'(proto_err), 256'(0));

        // Init sequence 3,3,3,2 then function set 0x28
        send_nib(1'b0, 1'b0, 4'h3);
        send_nib(1'b0, 1'b0, 4'h3);
        send_nib(1'b0, 1'b0, 4'h3);
        chk("init.four_bit_after3", 256'(four_bit), 256'(0));
        send_nib(1'b0, 1'b0, 4'h2);
        chk("init.four_bit_after4", 256'(four_bit), 256'(1));
        n = vld_cyc;
        send_byte(1'b0, 8'h28, 1'b0);
        chk("init.byte_28_pulse", 256'(vld_cyc - n), 256'(1));
        chk("init.byte_28_dat", 256'(last_byte), 256'(8'h28));
        chk("init.byte_28_rs", 256'(last_rs), 256'(0));
        send_byte(1'b0, 8'h0C, 1'b0);
        send_byte(1'b0, 8'h06, 1'b0);
        check_all("init");

        // "HI" at line 1 col 0
        send_byte(1'b0, 8'h80, 1'b0);
        send_byte(1'b1, 8'h48, 1'b0);
        send_byte(1'b1, 8'h49, 1'b0);
        chk("hi.top16", 256'(screen[255:240]), 256'(16'h4849));
        chk("hi.last_rs", 256'(last_rs), 256'(1));
        check_all("hi");

        // 17 'A's on line 2: 17th lands at 0x50 and is dropped
        send_byte(1'b0, 8'hC0, 1'b0);
        for (int i = 0; i < 17; i++) send_byte(1'b1, 8'h41, 1'b0);
        chk("line2.all_A", 256'(screen[127:0]), 256'({16{8'h41}}));
        check_all("line2");

        // Address wrap: 0x67 -> 0x00, 0x27 -> 0x40, and 0x27 dec -> 0x26
        send_byte(1'b0, 8'hE7, 1'b0);
        send_byte(1'b1, rand_char(), 1'b0);
        c = rand_char();
        send_byte(1'b1, c, 1'b0);
        chk("wrap.67_to_00", 256'(screen[255:248]), 256'(c));
        send_byte(1'b0, 8'hA7, 1'b0);
        send_byte(1'b1, rand_char(), 1'b0);
        c = rand_char();
        send_byte(1'b1, c, 1'b0);
        chk("wrap.27_to_40", 256'(screen[127:120]), 256'(c));
        send_byte(1'b0, 8'h04, 1'b0);
        send_byte(1'b0, 8'hA7, 1'b0);
        send_byte(1'b1, rand_char(), 1'b0);
        send_byte(1'b1, rand_char(), 1'b0);
        check_all("wrap.dec");
        send_byte(1'b0, 8'h06, 1'b0);

        // Randomised traffic with occasional RW=1 strobes between nibbles
        for (int i = 0; i < 30; i++) begin
            n = $urandom_range(0, 9);
            if (n < 3) send_byte(1'b0, rand_cmd(), n == 0);
            else       send_byte(1'b1, rand_char(), n == 3);
        end
        check_all("random");

        // Clear with a strobe landing inside the busy window
        send_nib(1'b0, 1'b0, 4'h0);
        b0 = busy_cyc;
        bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_dat = 4'h1;
        @(posedge clk); #1 bus.lcd_e = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.lcd_e = 1'b0;
        model_nib(1'b0, 1'b0, 4'h1);
        n = 0;
        while (!busy && n < 20) begin @(posedge clk); #1; n++; end
        chk("clr.busy_rise", 256'(busy), 256'(1));
        bus.lcd_rs = 1'b1; bus.lcd_dat = 4'h5; bus.lcd_e = 1'b1;
        @(posedge clk); #1 bus.lcd_e = 1'b0;
        exp_perr++;
        n = 0;
        while (busy && n < 100) begin @(posedge clk); #1; n++; end
        chk("clr.busy_fall", 256'(busy), 256'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("clr.busy_len", 256'(busy_cyc - b0), 256'(CLR));
        check_all("clr");
        c = rand_char();
        send_byte(1'b1, c, 1'b0);
        chk("clr.home_write", 256'(screen[255:248]), 256'(c));
        check_all("clr.after");

        // Reset while holding a lone high nibble
        send_nib(1'b0, 1'b0, 4'h4);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid.screen", screen, {32{8'h20}});
        chk("mid.four_bit", 256'(four_bit), 256'(0));
        chk("mid.disp_on", 256'(disp_on), 256'(0));
        chk("mid.byte_dat", 256'(byte_dat), 256'(0));
        chk("mid.busy", 256'(busy), 256'(0));
        chk("mid.byte_vld", 256'(byte_vld), 256'(0));
        chk("mid.proto_err", 256'(proto_err), 256'(0));
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        send_nib(1'b0, 1'b0, 4'h3);
        chk("mid.8bit_byte", 256'(last_byte), 256'(8'h30));
        check_all("mid.after3");
        send_nib(1'b0, 1'b0, 4'h2);
        check_all("mid.after2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
